// File: rtl/digital_clock_alarm.sv
// Binary HH:MM:SS clock with 1 Hz prescaler, runtime set, run/pause,
// optional 12-hour display and an HH:MM alarm with a sticky flag.
module digital_clock_alarm #(
  parameter int unsigned TICK_DIV     = 10_000_000,
  parameter bit          HOUR_MODE_12 = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_valid,
  input  logic [1:0] set_field,
  input  logic [5:0] set_value,
  output logic       set_err,
  input  logic       alarm_wr,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_en,
  input  logic       alarm_clr,
  output logic       alarm,
  output logic       tick,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic [5:0] hours_oeb,
  output logic [5:0] minutes_oeb,
  output logic [5:0] seconds_oeb
);

  localparam logic [31:0] PRESC_MAX = 32'(TICK_DIV - 1);

  logic [31:0] presc_q, presc_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d;
  logic [4:0]  hr_q, hr_d;
  logic [4:0]  alm_h_q, alm_h_d;
  logic [5:0]  alm_m_q, alm_m_d;
  logic        alarm_q, alarm_d;
  logic        set_err_q, set_err_d;
  logic        oeb_q;

  logic [5:0]  sec_adv, min_adv;
  logic [4:0]  hr_adv, hr_disp;
  logic        carry_s, carry_m, set_ok, alarm_hit;

  assign tick = run && (presc_q == PRESC_MAX);

  always_comb begin
    carry_s = tick && (sec_q == 6'd59);
    carry_m = carry_s && (min_q == 6'd59);
    sec_adv = tick    ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1) : sec_q;
    min_adv = carry_s ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1) : min_q;
    hr_adv  = carry_m ? ((hr_q  == 5'd23) ? 5'd0 : hr_q  + 5'd1) : hr_q;

    case (set_field)
      2'd0, 2'd1: set_ok = set_valid && (set_value <= 6'd59);
      2'd2:       set_ok = set_valid && (set_value <= 6'd23);
      default:    set_ok = 1'b0;
    endcase
    set_err_d = set_valid && !set_ok;

    // A written field takes the new value; any carry into it is dropped
    sec_d = (set_ok && set_field == 2'd0) ? set_value      : sec_adv;
    min_d = (set_ok && set_field == 2'd1) ? set_value      : min_adv;
    hr_d  = (set_ok && set_field == 2'd2) ? set_value[4:0] : hr_adv;

    if (set_ok && set_field == 2'd0)
      presc_d = 32'd0;
    else if (tick)
      presc_d = 32'd0;
    else if (run)
      presc_d = presc_q + 32'd1;
    else
      presc_d = presc_q;

    alm_h_d = alm_h_q;
    alm_m_d = alm_m_q;
    if (alarm_wr && alarm_hours <= 5'd23 && alarm_minutes <= 6'd59) begin
      alm_h_d = alarm_hours;
      alm_m_d = alarm_minutes;
    end

    // Compare against the tick-advanced time so set writes never fire it
    alarm_hit = tick && alarm_en && (sec_adv == 6'd0) &&
                (min_adv == alm_m_q) && (hr_adv == alm_h_q);
    if (alarm_hit)
      alarm_d = 1'b1;
    else if (alarm_clr)
      alarm_d = 1'b0;
    else
      alarm_d = alarm_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q   <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      alm_h_q   <= '0;
      alm_m_q   <= '0;
      alarm_q   <= 1'b0;
      set_err_q <= 1'b0;
      oeb_q     <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      alm_h_q   <= alm_h_d;
      alm_m_q   <= alm_m_d;
      alarm_q   <= alarm_d;
      set_err_q <= set_err_d;
      oeb_q     <= 1'b0;
    end
  end

  always_comb begin
    if (hr_q == 5'd0)
      hr_disp = 5'd12;
    else if (hr_q > 5'd12)
      hr_disp = hr_q - 5'd12;
    else
      hr_disp = hr_q;
  end

  assign hours       = HOUR_MODE_12 ? {1'b0, hr_disp} : {1'b0, hr_q};
  assign pm          = HOUR_MODE_12 && (hr_q >= 5'd12);
  assign minutes     = min_q;
  assign seconds     = sec_q;
  assign alarm       = alarm_q;
  assign set_err     = set_err_q;
  assign hours_oeb   = {6{oeb_q}};
  assign minutes_oeb = {6{oeb_q}};
  assign seconds_oeb = {6{oeb_q}};

endmodule

// File: tb/tb_digital_clock_alarm.sv
// Directed bench: a 24-hour and a 12-hour instance share all inputs.
module tb_digital_clock_alarm;

  logic       clk = 1'b0;
  logic       reset, run, set_valid, alarm_wr, alarm_en, alarm_clr;
  logic [1:0] set_field;
  logic [5:0] set_value, alarm_minutes;
  logic [4:0] alarm_hours;

  logic       set_err, alarm, tick, pm;
  logic [5:0] hours, minutes, seconds, hours_oeb, minutes_oeb, seconds_oeb;
  logic       set_err1, alarm1, tick1, pm1;
  logic [5:0] hours1, minutes1, seconds1, hoeb1, moeb1, soeb1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digital_clock_alarm #(.TICK_DIV(4), .HOUR_MODE_12(1'b0)) dut (
    .clk(clk), .reset(reset), .run(run), .set_valid(set_valid),
    .set_field(set_field), .set_value(set_value), .set_err(set_err),
    .alarm_wr(alarm_wr), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_en(alarm_en), .alarm_clr(alarm_clr), .alarm(alarm), .tick(tick),
    .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm),
    .hours_oeb(hours_oeb), .minutes_oeb(minutes_oeb), .seconds_oeb(seconds_oeb)
  );

  digital_clock_alarm #(.TICK_DIV(4), .HOUR_MODE_12(1'b1)) dut12 (
    .clk(clk), .reset(reset), .run(run), .set_valid(set_valid),
    .set_field(set_field), .set_value(set_value), .set_err(set_err1),
    .alarm_wr(alarm_wr), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_en(alarm_en), .alarm_clr(alarm_clr), .alarm(alarm1), .tick(tick1),
    .hours(hours1), .minutes(minutes1), .seconds(seconds1), .pm(pm1),
    .hours_oeb(hoeb1), .minutes_oeb(moeb1), .seconds_oeb(soeb1)
  );

  typedef struct {
    logic [1:0] fld;
    logic [5:0] val;
    logic [5:0] h, m, s;
    logic       err;
    logic [5:0] h12;
    logic       pm12;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_h"}, hours, h);
    chk({name, "_m"}, minutes, m);
    chk({name, "_s"}, seconds, s);
  endtask

  task automatic write_field(input logic [1:0] f, input logic [5:0] v);
    set_valid = 1'b1;
    set_field = f;
    set_value = v;
    step();
    set_valid = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    write_field(2'd2, 6'(h));
    write_field(2'd1, 6'(m));
    write_field(2'd0, 6'(s));
  endtask

  // Run until tick is seen, let the advancing edge happen, then pause
  task automatic run_until_tick(input string name);
    run = 1'b1;
    #1;
    for (int i = 0; i < 20 && !tick; i++) step();
    chk({name, "_tick_seen"}, tick, 1);
    step();
    run = 1'b0;
    #1;
  endtask

  initial begin
    tbl[0] = '{2'd2, 6'd23, 6'd23, 6'd0,  6'd1,  1'b0, 6'd11, 1'b1};
    tbl[1] = '{2'd1, 6'd59, 6'd23, 6'd59, 6'd1,  1'b0, 6'd11, 1'b1};
    tbl[2] = '{2'd0, 6'd59, 6'd23, 6'd59, 6'd59, 1'b0, 6'd11, 1'b1};
    tbl[3] = '{2'd1, 6'd60, 6'd23, 6'd59, 6'd59, 1'b1, 6'd11, 1'b1};
    tbl[4] = '{2'd3, 6'd5,  6'd23, 6'd59, 6'd59, 1'b1, 6'd11, 1'b1};
    tbl[5] = '{2'd2, 6'd24, 6'd23, 6'd59, 6'd59, 1'b1, 6'd11, 1'b1};
    tbl[6] = '{2'd0, 6'd60, 6'd23, 6'd59, 6'd59, 1'b1, 6'd11, 1'b1};
    tbl[7] = '{2'd2, 6'd12, 6'd12, 6'd59, 6'd59, 1'b0, 6'd12, 1'b1};
    tbl[8] = '{2'd2, 6'd13, 6'd13, 6'd59, 6'd59, 1'b0, 6'd1,  1'b1};
    tbl[9] = '{2'd2, 6'd23, 6'd23, 6'd59, 6'd59, 1'b0, 6'd11, 1'b1};

    reset = 1'b0; run = 1'b0; set_valid = 1'b0; set_field = 2'd0; set_value = 6'd0;
    alarm_wr = 1'b0; alarm_hours = 5'd0; alarm_minutes = 6'd0;
    alarm_en = 1'b0; alarm_clr = 1'b0;

    step(); step();
    chk("rst_oeb_h", hours_oeb, 6'h3F);
    chk("rst_oeb_m", minutes_oeb, 6'h3F);
    chk("rst_oeb_s", seconds_oeb, 6'h3F);
    chk_time("rst", 0, 0, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_set_err", set_err, 0);
    chk("rst_tick", tick, 0);

    reset = 1'b1;
    step();
    chk("oeb_h_after", hours_oeb, 0);
    chk("oeb_m_after", minutes_oeb, 0);
    chk("oeb_s_after", seconds_oeb, 0);

    // Prescaler: tick on the 4th cycle of run
    run = 1'b1;
    #1;
    chk("tick_c0", tick, 0);
    step(); chk("tick_c1", tick, 0);
    step(); chk("tick_c2", tick, 0);
    step(); chk("tick_c3", tick, 1);
    chk("sec_before_tick", seconds, 0);
    step(); chk("tick_c4", tick, 0);
    chk("sec_after_tick", seconds, 1);
    run = 1'b0;

    // Set-field vectors (time held with run=0)
    for (int i = 0; i < 10; i++) begin
      write_field(tbl[i].fld, tbl[i].val);
      chk($sformatf("vec%0d_h", i), hours, tbl[i].h);
      chk($sformatf("vec%0d_m", i), minutes, tbl[i].m);
      chk($sformatf("vec%0d_s", i), seconds, tbl[i].s);
      chk($sformatf("vec%0d_err", i), set_err, tbl[i].err);
      chk($sformatf("vec%0d_h12", i), hours1, tbl[i].h12);
      chk($sformatf("vec%0d_pm", i), pm1, tbl[i].pm12);
      chk($sformatf("vec%0d_pm24", i), pm, 0);
      step();
      chk($sformatf("vec%0d_err_clr", i), set_err, 0);
    end

    run_until_tick("roll");
    chk_time("roll", 0, 0, 0);
    chk("roll_h12", hours1, 12);
    chk("roll_pm12", pm1, 0);

    set_time(5, 59, 59);
    run_until_tick("hcarry");
    chk_time("hcarry", 6, 0, 0);

    // Seconds write mid-count restarts the prescaler
    run = 1'b1;
    step(); step();
    write_field(2'd0, 6'd5);
    chk("midset_s", seconds, 5);
    chk("midset_t1", tick, 0);
    step(); chk("midset_t2", tick, 0);
    step(); chk("midset_t3", tick, 0);
    step(); chk("midset_t4", tick, 1);
    step(); chk("midset_s_next", seconds, 6);
    run = 1'b0;

    // Alarm
    alarm_hours = 5'd7; alarm_minutes = 6'd30; alarm_wr = 1'b1; alarm_en = 1'b1;
    step();
    alarm_wr = 1'b0;
    set_time(7, 29, 59);
    chk("alm_pre", alarm, 0);
    run_until_tick("alm");
    chk_time("alm", 7, 30, 0);
    chk("alm_set", alarm, 1);
    step();
    chk("alm_sticky", alarm, 1);
    alarm_clr = 1'b1;
    step();
    chk("alm_clr", alarm, 0);
    set_time(7, 29, 59);
    run_until_tick("almclr");
    chk("alm_set_wins", alarm, 1);
    step();
    chk("alm_clr2", alarm, 0);
    alarm_clr = 1'b0;
    alarm_en = 1'b0;
    set_time(7, 29, 59);
    run_until_tick("almdis");
    chk_time("almdis", 7, 30, 0);
    chk("alm_disabled", alarm, 0);

    // Seconds write in the tick cycle at 00:00:59
    set_time(0, 0, 59);
    run = 1'b1;
    step(); step(); step();
    chk("settick_tick", tick, 1);
    write_field(2'd0, 6'd10);
    run = 1'b0;
    chk_time("settick", 0, 1, 10);

    // Pause: no ticks, no change
    begin
      int ticks = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (tick) ticks++;
      end
      chk("pause_ticks", ticks, 0);
      chk_time("pause", 0, 1, 10);
    end

    // Reset mid-count overrides writes
    run = 1'b1;
    step(); step();
    reset = 1'b0; set_valid = 1'b1; set_field = 2'd1; set_value = 6'd30;
    alarm_wr = 1'b1;
    step();
    chk_time("midrst", 0, 0, 0);
    chk("midrst_oeb", seconds_oeb, 6'h3F);
    chk("midrst_err", set_err, 0);
    chk("midrst_tick", tick, 0);
    reset = 1'b1; set_valid = 1'b0; alarm_wr = 1'b0; run = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
